fifo_ctrl_mc: RTL and testbench
===============================

FIFO_CTRL_MC -- requirements
Module: fifo_ctrl_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent FIFO channels sharing one control block.
REQ-002 Parameter MEM_SIZE, default 8, entries per channel; any value >= 2, power of two not required.
REQ-003 Parameter PTR_L, default 3, pointer width; SHALL satisfy 2**PTR_L >= MEM_SIZE.
REQ-004 Parameter CNT_L, default 4, occupancy width; SHALL satisfy 2**CNT_L > MEM_SIZE.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 fifo_wr  in  NUM_CH  per-channel write request.
REQ-008 fifo_rd  in  NUM_CH  per-channel read request.
REQ-009 full_threshold  in  CNT_L  almost-full level, shared by all channels.
REQ-010 empty_threshold  in  CNT_L  almost-empty level, shared by all channels.
REQ-011 err_clr  in  NUM_CH  per-channel sticky-error clear.
REQ-012 wr_en / rd_en  out  NUM_CH each  qualified (accepted) write/read strobes to the memory.
REQ-013 wr_ptr / rd_ptr  out  NUM_CH*PTR_L each  per-channel addresses, channel i at bits [i*PTR_L +: PTR_L].
REQ-014 count  out  NUM_CH*CNT_L  per-channel occupancy, channel i at [i*CNT_L +: CNT_L].
REQ-015 fifo_full, fifo_empty, almost_full, almost_empty, error  out  NUM_CH each  per-channel status.

Function
REQ-016 Channels SHALL be fully independent; no request on one channel SHALL affect another channel's state.
REQ-017 Status flags SHALL be combinational from count: fifo_full = (count==MEM_SIZE), fifo_empty = (count==0), almost_full = (count>=full_threshold), almost_empty = (count<=empty_threshold).
REQ-018 wr_en SHALL be 1 when fifo_wr=1 and (not full, or full with fifo_rd=1); rd_en SHALL be 1 when fifo_rd=1 and not empty; both combinational, same cycle as request.
REQ-019 On each edge: count += wr_en - rd_en; wr_ptr advances by 1 on wr_en; rd_ptr advances by 1 on rd_en.
REQ-020 Pointers SHALL wrap from MEM_SIZE-1 to 0, never reaching MEM_SIZE.
REQ-021 Simultaneous rd+wr, channel neither full nor empty: both accepted, count unchanged, both pointers advance.
REQ-022 Simultaneous rd+wr on full channel: both accepted, count stays MEM_SIZE, no error.
REQ-023 Simultaneous rd+wr on empty channel: write accepted, read rejected, count becomes 1, error set.
REQ-024 Write-only on full or read-only on empty: request rejected, count and pointers unchanged, error set on next edge.
REQ-025 error SHALL be sticky until err_clr=1 on that channel; if a new error and err_clr coincide, error SHALL remain 1.
REQ-026 full_threshold > MEM_SIZE: almost_full never asserts; empty_threshold = 0: almost_empty equals fifo_empty.
REQ-027 count SHALL never exceed MEM_SIZE nor underflow below 0.

Reset
REQ-028 reset=1 SHALL immediately, independent of clk, force count=0, wr_ptr=0, rd_ptr=0, error=0 on all channels.
REQ-029 During and after reset outputs follow REQ-017: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0 (full_threshold>0), wr_en/rd_en gated to 0.
REQ-030 Reset asserted mid-transfer SHALL discard all occupancy; first edge after deassertion behaves as from empty.

Verification
REQ-031 MEM_SIZE=8: 8 writes ch0 -> count0=8, fifo_full[0]=1, wr_ptr0 wraps to 0; 9th write -> wr_en[0]=0, error[0]=1, count0=8.
REQ-032 Empty ch1, read -> rd_en[1]=0, error[1]=1; err_clr[1] one cycle -> error[1]=0; err_clr with new bad read -> error[1] stays 1.
REQ-033 Full ch2, rd+wr same cycle -> wr_en=rd_en=1, count2=8, both pointers advance by 1, error[2]=0.
REQ-034 full_threshold=6, empty_threshold=2: fill ch3 0->8 -> almost_empty for count<=2, almost_full for count>=6, exact transitions at 3 and 6.
REQ-035 MEM_SIZE=5, PTR_L=3: 12 write/read pairs -> pointers sequence 0..4,0..4,0,1; never 5..7.
REQ-036 Ch0 count=5, reset pulsed between edges -> count0=0, pointers 0, fifo_empty[0]=1 before next clk edge; other channels also cleared.

Source files
------------

// File: rtl/fifo_ctrl_mc_if.sv
// fifo_ctrl_mc_if -- request/status bundle for the multi-channel FIFO controller.
//
// Ports (signals in the bundle):
//   fifo_wr, fifo_rd, err_clr      NUM_CH           per-channel requests / error clear
//   full_threshold, empty_threshold CNT_L           shared almost-full / almost-empty levels
//   wr_en, rd_en                   NUM_CH           accepted write / read strobes to memory
//   wr_ptr, rd_ptr                 NUM_CH*PTR_L     per-channel addresses, ch i at [i*PTR_L +: PTR_L]
//   count                          NUM_CH*CNT_L     per-channel occupancy, ch i at [i*CNT_L +: CNT_L]
//   fifo_full, fifo_empty, almost_full, almost_empty, error  NUM_CH  per-channel status
// Modports: master drives requests and observes status; slave is the controller.
interface fifo_ctrl_mc_if #(
  parameter int NUM_CH = 4,
  parameter int PTR_L  = 3,
  parameter int CNT_L  = 4
);
  logic [NUM_CH-1:0]       fifo_wr;
  logic [NUM_CH-1:0]       fifo_rd;
  logic [NUM_CH-1:0]       err_clr;
  logic [CNT_L-1:0]        full_threshold;
  logic [CNT_L-1:0]        empty_threshold;
  logic [NUM_CH-1:0]       wr_en;
  logic [NUM_CH-1:0]       rd_en;
  logic [NUM_CH*PTR_L-1:0] wr_ptr;
  logic [NUM_CH*PTR_L-1:0] rd_ptr;
  logic [NUM_CH*CNT_L-1:0] count;
  logic [NUM_CH-1:0]       fifo_full;
  logic [NUM_CH-1:0]       fifo_empty;
  logic [NUM_CH-1:0]       almost_full;
  logic [NUM_CH-1:0]       almost_empty;
  logic [NUM_CH-1:0]       error;

  modport master (
    output fifo_wr, fifo_rd, err_clr, full_threshold, empty_threshold,
    input  wr_en, rd_en, wr_ptr, rd_ptr, count,
    input  fifo_full, fifo_empty, almost_full, almost_empty, error
  );

  modport slave (
    input  fifo_wr, fifo_rd, err_clr, full_threshold, empty_threshold,
    output wr_en, rd_en, wr_ptr, rd_ptr, count,
    output fifo_full, fifo_empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/fifo_ctrl_mc.sv
// fifo_ctrl_mc -- control block for NUM_CH independent FIFOs of MEM_SIZE entries each.
// Produces accepted write/read strobes, wrapping read/write addresses, occupancy,
// full/empty/almost flags and a sticky per-channel error for rejected requests.
//
// Ports:
//   clk    in  single clock, state updates on rising edge
//   reset  in  asynchronous active-high reset, clears all channels immediately
//   bus    slave side of fifo_ctrl_mc_if (requests in, strobes/pointers/status out)
module fifo_ctrl_mc #(
  parameter int NUM_CH   = 4,
  parameter int MEM_SIZE = 8,
  parameter int PTR_L    = 3,
  parameter int CNT_L    = 4
) (
  input  logic           clk,
  input  logic           reset,
  fifo_ctrl_mc_if.slave  bus
);

  localparam logic [CNT_L-1:0] FULL_CNT = CNT_L'(MEM_SIZE);
  localparam logic [PTR_L-1:0] LAST_PTR = PTR_L'(MEM_SIZE - 1);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_L-1:0] count_q, count_d;
      logic [PTR_L-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_L-1:0] rd_ptr_q, rd_ptr_d;
      logic             error_q, error_d;
      logic             full, empty, wr_acc, rd_acc, reject;

      always_comb begin
        full   = (count_q == FULL_CNT);
        empty  = (count_q == '0);
        // A write into a full channel is only safe when a read frees a slot
        // in the same cycle. Strobes are held low while reset is asserted.
        wr_acc = bus.fifo_wr[gi] & (~full | bus.fifo_rd[gi]) & ~reset;
        rd_acc = bus.fifo_rd[gi] & ~empty & ~reset;
        // Any request that was presented but not accepted is an error.
        reject = (bus.fifo_wr[gi] & ~wr_acc) | (bus.fifo_rd[gi] & ~rd_acc);

        count_d  = count_q + {{(CNT_L-1){1'b0}}, wr_acc} - {{(CNT_L-1){1'b0}}, rd_acc};
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

        // A new error wins over a coincident clear.
        error_d = error_q;
        if (bus.err_clr[gi]) error_d = 1'b0;
        if (reject)          error_d = 1'b1;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_q  <= '0;
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          error_q  <= 1'b0;
        end else begin
          count_q  <= count_d;
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          error_q  <= error_d;
        end
      end

      assign bus.wr_en[gi]                    = wr_acc;
      assign bus.rd_en[gi]                    = rd_acc;
      assign bus.wr_ptr[gi*PTR_L +: PTR_L]    = wr_ptr_q;
      assign bus.rd_ptr[gi*PTR_L +: PTR_L]    = rd_ptr_q;
      assign bus.count[gi*CNT_L +: CNT_L]     = count_q;
      assign bus.fifo_full[gi]                = full;
      assign bus.fifo_empty[gi]               = empty;
      assign bus.almost_full[gi]              = (count_q >= bus.full_threshold);
      assign bus.almost_empty[gi]             = (count_q <= bus.empty_threshold);
      assign bus.error[gi]                    = error_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_ctrl_mc.sv
// tb_fifo_ctrl_mc -- drives two controllers (MEM_SIZE 8 and MEM_SIZE 5) with identical
// directed and random request patterns and compares every output each cycle against
// an occupancy/pointer model built from plain arithmetic.
module tb_fifo_ctrl_mc;
  localparam int NCH = 4;
  localparam int PW  = 3;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_ctrl_mc_if #(.NUM_CH(NCH), .PTR_L(PW), .CNT_L(CW)) if8 ();
  fifo_ctrl_mc_if #(.NUM_CH(NCH), .PTR_L(PW), .CNT_L(CW)) if5 ();

  fifo_ctrl_mc #(.NUM_CH(NCH), .MEM_SIZE(8), .PTR_L(PW), .CNT_L(CW)) dut8 (
    .clk(clk), .reset(reset), .bus(if8.slave)
  );
  fifo_ctrl_mc #(.NUM_CH(NCH), .MEM_SIZE(5), .PTR_L(PW), .CNT_L(CW)) dut5 (
    .clk(clk), .reset(reset), .bus(if5.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: index 0 -> MEM_SIZE 8 instance, 1 -> MEM_SIZE 5 instance.
  int msize [2] = '{8, 5};
  int m_cnt [2][NCH];
  int m_wp  [2][NCH];
  int m_rp  [2][NCH];
  bit m_err [2][NCH];

  logic [NCH-1:0] wr_v, rd_v, clr_v;
  logic [CW-1:0]  ft_v, et_v;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_inputs();
    if8.fifo_wr = wr_v;  if8.fifo_rd = rd_v;  if8.err_clr = clr_v;
    if8.full_threshold = ft_v;  if8.empty_threshold = et_v;
    if5.fifo_wr = wr_v;  if5.fifo_rd = rd_v;  if5.err_clr = clr_v;
    if5.full_threshold = ft_v;  if5.empty_threshold = et_v;
  endtask

  function automatic bit acc_wr(int d, int c);
    return !reset && wr_v[c] && (m_cnt[d][c] < msize[d] || rd_v[c]);
  endfunction

  function automatic bit acc_rd(int d, int c);
    return !reset && rd_v[c] && (m_cnt[d][c] > 0);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        m_cnt[d][c] = 0; m_wp[d][c] = 0; m_rp[d][c] = 0; m_err[d][c] = 1'b0;
      end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        bit we, re, bad;
        we  = acc_wr(d, c);
        re  = acc_rd(d, c);
        bad = (wr_v[c] && !we) || (rd_v[c] && !re);
        m_cnt[d][c] = m_cnt[d][c] + int'(we) - int'(re);
        m_wp[d][c]  = (m_wp[d][c] + int'(we)) % msize[d];
        m_rp[d][c]  = (m_rp[d][c] + int'(re)) % msize[d];
        if (bad)           m_err[d][c] = 1'b1;
        else if (clr_v[c]) m_err[d][c] = 1'b0;
      end
  endtask

  task automatic check_dut(input int d);
    logic [NCH-1:0]    e_we, e_re, e_full, e_empty, e_af, e_ae, e_err;
    logic [NCH-1:0]    g_we, g_re, g_full, g_empty, g_af, g_ae, g_err;
    logic [NCH*PW-1:0] e_wp, e_rp, g_wp, g_rp;
    logic [NCH*CW-1:0] e_cnt, g_cnt;
    string p;
    p = $sformatf("m%0d.", msize[d]);
    for (int c = 0; c < NCH; c++) begin
      e_we[c]          = acc_wr(d, c);
      e_re[c]          = acc_rd(d, c);
      e_full[c]        = (m_cnt[d][c] == msize[d]);
      e_empty[c]       = (m_cnt[d][c] == 0);
      e_af[c]          = (m_cnt[d][c] >= int'(ft_v));
      e_ae[c]          = (m_cnt[d][c] <= int'(et_v));
      e_err[c]         = m_err[d][c];
      e_wp[c*PW +: PW] = PW'(m_wp[d][c]);
      e_rp[c*PW +: PW] = PW'(m_rp[d][c]);
      e_cnt[c*CW +: CW] = CW'(m_cnt[d][c]);
    end
    if (d == 0) begin
      g_we = if8.wr_en; g_re = if8.rd_en; g_full = if8.fifo_full; g_empty = if8.fifo_empty;
      g_af = if8.almost_full; g_ae = if8.almost_empty; g_err = if8.error;
      g_wp = if8.wr_ptr; g_rp = if8.rd_ptr; g_cnt = if8.count;
    end else begin
      g_we = if5.wr_en; g_re = if5.rd_en; g_full = if5.fifo_full; g_empty = if5.fifo_empty;
      g_af = if5.almost_full; g_ae = if5.almost_empty; g_err = if5.error;
      g_wp = if5.wr_ptr; g_rp = if5.rd_ptr; g_cnt = if5.count;
    end
    check_val({p, "wr_en"},        32'(g_we),    32'(e_we));
    check_val({p, "rd_en"},        32'(g_re),    32'(e_re));
    check_val({p, "count"},        32'(g_cnt),   32'(e_cnt));
    check_val({p, "wr_ptr"},       32'(g_wp),    32'(e_wp));
    check_val({p, "rd_ptr"},       32'(g_rp),    32'(e_rp));
    check_val({p, "fifo_full"},    32'(g_full),  32'(e_full));
    check_val({p, "fifo_empty"},   32'(g_empty), 32'(e_empty));
    check_val({p, "almost_full"},  32'(g_af),    32'(e_af));
    check_val({p, "almost_empty"}, 32'(g_ae),    32'(e_ae));
    check_val({p, "error"},        32'(g_err),   32'(e_err));
  endtask

  // One transaction: entered at posedge+1, checked at posedge+2, returns at next posedge+1.
  task automatic cycle(input logic [NCH-1:0] wr, input logic [NCH-1:0] rd, input logic [NCH-1:0] clr);
    wr_v = wr; rd_v = rd; clr_v = clr;
    apply_inputs();
    #1;
    check_dut(0);
    check_dut(1);
    $display("txn wr=%b rd=%b clr=%b ft=%0d et=%0d cnt8=%h cnt5=%h err8=%b err5=%b",
             wr, rd, clr, ft_v, et_v, if8.count, if5.count, if8.error, if5.error);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int fill_bias;
    reset = 1'b1;
    wr_v = '1; rd_v = '1; clr_v = '0; ft_v = 4'd6; et_v = 4'd2;
    apply_inputs();
    model_reset();
    #2;
    // During reset: strobes gated even with requests present, status at empty.
    check_dut(0);
    check_dut(1);
    wr_v = '0; rd_v = '0;
    apply_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ch0: 8 writes fill, 9th rejected with error.
    repeat (9) cycle(4'b0001, 4'b0000, 4'b0000);
    check_val("ch0_full_count", 32'(if8.count[3:0]), 32'd8);
    check_val("ch0_error", 32'(if8.error[0]), 32'd1);

    // Ch1: read on empty, clear, then clear coinciding with a new bad read.
    cycle(4'b0000, 4'b0010, 4'b0000);
    cycle(4'b0000, 4'b0000, 4'b0010);
    cycle(4'b0000, 4'b0010, 4'b0010);
    cycle(4'b0000, 4'b0000, 4'b0000);
    check_val("ch1_sticky", 32'(if8.error[1]), 32'd1);

    // Ch2: fill then simultaneous rd+wr on full.
    repeat (8) cycle(4'b0100, 4'b0000, 4'b0000);
    cycle(4'b0100, 4'b0100, 4'b0000);

    // Ch3: fill from empty observing threshold transitions.
    repeat (8) cycle(4'b1000, 4'b0000, 4'b0000);

    // Drain everything, then rd+wr on empty channels.
    cycle(4'b0000, 4'b0000, 4'b1111);
    repeat (9) cycle(4'b0000, 4'b1111, 4'b0000);
    cycle(4'b1111, 4'b1111, 4'b1111);

    // Ch0 to count 5 (other channels partially), then reset between edges.
    repeat (4) cycle(4'b0011, 4'b0000, 4'b0000);
    #2;
    reset = 1'b1;
    wr_v = '1; rd_v = '0;
    apply_inputs();
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    wr_v = '0; rd_v = '0; clr_v = '0;
    apply_inputs();
    #1;
    reset = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    cycle(4'b0001, 4'b0001, 4'b0000);

    // Randomized traffic with alternating fill/drain bias and varying thresholds.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] w, r, k;
      if (i % 40 == 0) begin
        ft_v = CW'($urandom_range(0, 15));
        et_v = (i % 80 == 0) ? 4'd0 : CW'($urandom_range(0, 8));
      end
      fill_bias = ((i / 25) % 2 == 0) ? 75 : 25;
      for (int c = 0; c < NCH; c++) begin
        w[c] = ($urandom_range(0, 99) < fill_bias);
        r[c] = ($urandom_range(0, 99) < (100 - fill_bias));
        k[c] = ($urandom_range(0, 99) < 10);
      end
      cycle(w, r, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
